// File: rtl/instr_sequencer.sv
// Byte-serial instruction fetcher: reads opcode/operand bytes from a synchronous
// program memory, assembles them into one instruction and hands it over on a valid/ready port.
module instr_sequencer #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 8,
  parameter int PROG_LEN = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              issue_valid,
  input  logic              issue_ready,
  output logic [DATA_W-1:0] issue_opcode,
  output logic [DATA_W-1:0] issue_op1,
  output logic [DATA_W-1:0] issue_op2,
  output logic [1:0]        issue_nops,
  output logic              halted,
  output logic              done,
  output logic [ADDR_W-1:0] pc
);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_CAP, S_ISSUE, S_HALTED, S_DONE
  } state_t;

  // One extra pc bit lets pc hold PROG_LEN even when PROG_LEN == 2**ADDR_W.
  localparam int              PC_W    = ADDR_W + 1;
  localparam logic [PC_W-1:0] PC_END  = PC_W'(PROG_LEN);
  localparam logic [7:0]      OP_HALT = 8'h13;

  function automatic logic [1:0] decode_nops(input logic [7:0] op);
    if (op <= 8'h0B)      return 2'd2;
    else if (op <= 8'h14) return 2'd1;
    else                  return 2'd0;
  endfunction

  state_t            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d, pc_inc;
  logic [1:0]        idx_q, idx_d;
  logic [1:0]        nops_q, nops_d, cap_nops;
  logic [DATA_W-1:0] opcode_q, opcode_d;
  logic [DATA_W-1:0] op1_q, op1_d;
  logic [DATA_W-1:0] op2_q, op2_d;

  assign pc_inc   = pc_q + PC_W'(1);
  // While the opcode byte is arriving its operand count comes straight from the bus.
  assign cap_nops = (idx_q == 2'd0) ? decode_nops(mem_rdata[7:0]) : nops_q;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    idx_d    = idx_q;
    nops_d   = nops_q;
    opcode_d = opcode_q;
    op1_d    = op1_q;
    op2_d    = op2_q;
    case (state_q)
      S_IDLE, S_HALTED, S_DONE: begin
        if (start) begin
          pc_d    = '0;
          idx_d   = '0;
          state_d = S_REQ;
        end
      end
      S_REQ: state_d = S_CAP;
      S_CAP: begin
        case (idx_q)
          2'd0: begin
            opcode_d = mem_rdata;
            op1_d    = '0;
            op2_d    = '0;
            nops_d   = cap_nops;
          end
          2'd1:    op1_d = mem_rdata;
          default: op2_d = mem_rdata;
        endcase
        pc_d = pc_inc;
        // Running out of program ends the instruction early; missing operands stay zero.
        if (idx_q == cap_nops || pc_inc == PC_END) begin
          state_d = S_ISSUE;
        end else begin
          idx_d   = idx_q + 2'd1;
          state_d = S_REQ;
        end
      end
      S_ISSUE: begin
        if (issue_ready) begin
          if (opcode_q[7:0] == OP_HALT) begin
            state_d = S_HALTED;
          end else if (pc_q == PC_END) begin
            state_d = S_DONE;
          end else begin
            idx_d   = '0;
            state_d = S_REQ;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      idx_q    <= '0;
      nops_q   <= '0;
      opcode_q <= '0;
      op1_q    <= '0;
      op2_q    <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      idx_q    <= idx_d;
      nops_q   <= nops_d;
      opcode_q <= opcode_d;
      op1_q    <= op1_d;
      op2_q    <= op2_d;
    end
  end

  // The address bus is only non-zero during an actual read request.
  assign mem_addr     = (state_q == S_REQ) ? pc_q[ADDR_W-1:0] : '0;
  assign pc           = pc_q[ADDR_W-1:0];
  assign issue_valid  = (state_q == S_ISSUE);
  assign issue_opcode = opcode_q;
  assign issue_op1    = op1_q;
  assign issue_op2    = op2_q;
  assign issue_nops   = nops_q;
  assign halted       = (state_q == S_HALTED);
  assign done         = (state_q == S_DONE);

endmodule
